// File: rtl/athos_pkg.sv
// rtl/athos_pkg.sv - shared Kyber constants, compress-mode encoding and pack FSM states
package athos_pkg;

    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned ROUND_C = 1664;

    typedef enum logic [2:0] {
        MODE_D1  = 3'd0,
        MODE_D4  = 3'd1,
        MODE_D5  = 3'd2,
        MODE_D10 = 3'd3,
        MODE_D11 = 3'd4
    } compress_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Reserved encodings fall back to d=1 so the stream stays well formed.
    function automatic logic [3:0] mode_to_d(input logic [2:0] mode);
        case (mode)
            MODE_D4:  return 4'd4;
            MODE_D5:  return 4'd5;
            MODE_D10: return 4'd10;
            MODE_D11: return 4'd11;
            default:  return 4'd1;
        endcase
    endfunction

    function automatic logic mode_reserved(input logic [2:0] mode);
        return (mode > MODE_D11);
    endfunction

endpackage

// File: rtl/poly_compress_coeff.sv
// rtl/poly_compress_coeff.sv - combinational Kyber compress of one coefficient to d bits
module poly_compress_coeff
    import athos_pkg::*;
#(
    parameter int unsigned Q = KYBER_Q
) (
    input  logic [15:0] x_i,
    input  logic [3:0]  d_i,
    output logic [10:0] c_o
);

    logic [15:0] w_xr;
    logic [11:0] w_x12;
    logic [23:0] w_num;
    logic [23:0] w_quot;
    logic [23:0] w_mask;

    // One conditional subtraction, then only the low 12 bits feed the divider.
    always_comb begin
        w_xr = x_i;
        if ((x_i >= 16'(Q)) && (x_i < 16'(2 * Q))) begin
            w_xr = x_i - 16'(Q);
        end
        w_x12  = 12'(w_xr);
        w_num  = (24'(w_x12) << d_i) + 24'(ROUND_C);
        w_quot = w_num / 24'(Q);
        w_mask = (24'd1 << d_i) - 24'd1;
        c_o    = 11'(w_quot & w_mask);
    end

endmodule

// File: rtl/poly_compress_pack.sv
// rtl/poly_compress_pack.sv - compress and little-endian bit-pack one polynomial into 32-bit words; option ATHOS_COMPRESS_RANGE_CHECK_EN
module poly_compress_pack
    import athos_pkg::*;
#(
    parameter int unsigned NCOEFF = 256,
    parameter int unsigned Q      = KYBER_Q
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  mode_i,
    input  logic [15:0] coeff_i,
    input  logic        coeff_valid_i,
    output logic        coeff_ready_o,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned CNT_W  = $clog2(NCOEFF + 1);
    localparam int unsigned WCNT_W = $clog2((NCOEFF * 11) / 32 + 1);

    state_e              r_state;
    state_e              w_state_n;
    logic [3:0]          r_d;
    logic                r_err;
    logic [63:0]         r_acc;
    logic [6:0]          r_fill;
    logic [CNT_W-1:0]    r_acc_cnt;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [WCNT_W-1:0]   r_word_total;
    logic                r_pipe_valid;
    logic [10:0]         r_pipe_c;

    logic                w_start_acc;
    logic [3:0]          w_start_d;
    logic [WCNT_W-1:0]   w_start_total;
    logic                w_word_valid;
    logic                w_extract;
    logic                w_last_word;
    logic [6:0]          w_fill_ext;
    logic [6:0]          w_fill_pend;
    logic                w_room;
    logic                w_coeff_ready;
    logic                w_coeff_acc;
    logic                w_range_err;
    logic [10:0]         w_c;
    logic [63:0]         w_ins;
    logic [63:0]         w_acc_n;

    assign w_start_acc   = start_i && (r_state == ST_IDLE);
    assign w_start_d     = mode_to_d(mode_i);
    assign w_start_total = WCNT_W'((NCOEFF * 32'(w_start_d)) / 32);

    assign w_word_valid = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && (r_fill >= 7'd32);
    assign w_extract    = w_word_valid && word_ready_i;
    assign w_last_word  = (r_word_cnt == (r_word_total - 1'b1));

    // Room must also cover the coefficient already sitting in the compute register.
    assign w_fill_ext    = w_extract ? (r_fill - 7'd32) : r_fill;
    assign w_fill_pend   = w_fill_ext + (r_pipe_valid ? {3'd0, r_d} : 7'd0);
    assign w_room        = (w_fill_pend + {3'd0, r_d}) <= 7'd64;
    assign w_coeff_ready = (r_state == ST_RUN) && (r_acc_cnt < CNT_W'(NCOEFF)) && w_room;
    assign w_coeff_acc   = coeff_valid_i && w_coeff_ready;

`ifdef ATHOS_COMPRESS_RANGE_CHECK_EN
    assign w_range_err = w_coeff_acc && (coeff_i >= 16'(2 * Q));
`else
    assign w_range_err = 1'b0;
`endif

    poly_compress_coeff #(
        .Q (Q)
    ) u_coeff (
        .x_i (coeff_i),
        .d_i (r_d),
        .c_o (w_c)
    );

    assign w_ins   = 64'(r_pipe_c) << w_fill_ext;
    assign w_acc_n = (w_extract ? {32'd0, r_acc[63:32]} : r_acc) | (r_pipe_valid ? w_ins : 64'd0);

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_acc) w_state_n = ST_RUN;
            ST_RUN:   if (w_coeff_acc && (r_acc_cnt == CNT_W'(NCOEFF - 1))) w_state_n = ST_DRAIN;
            ST_DRAIN: if (w_extract && w_last_word) w_state_n = ST_DONE;
            ST_DONE:  w_state_n = ST_IDLE;
            default:  w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_d          <= 4'd1;
            r_err        <= 1'b0;
            r_acc        <= 64'd0;
            r_fill       <= 7'd0;
            r_acc_cnt    <= '0;
            r_word_cnt   <= '0;
            r_word_total <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_c     <= 11'd0;
        end else if (w_start_acc) begin
            r_d          <= w_start_d;
            r_err        <= mode_reserved(mode_i);
            r_acc        <= 64'd0;
            r_fill       <= 7'd0;
            r_acc_cnt    <= '0;
            r_word_cnt   <= '0;
            r_word_total <= w_start_total;
            r_pipe_valid <= 1'b0;
            r_pipe_c     <= 11'd0;
        end else begin
            r_pipe_valid <= w_coeff_acc;
            if (w_coeff_acc) begin
                r_pipe_c  <= w_c;
                r_acc_cnt <= r_acc_cnt + 1'b1;
            end
            r_acc  <= w_acc_n;
            r_fill <= w_fill_pend;
            if (w_extract) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_range_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign coeff_ready_o = w_coeff_ready;
    assign word_valid_o  = w_word_valid;
    assign word_o        = w_word_valid ? r_acc[31:0] : 32'd0;
    assign last_o        = w_word_valid && w_last_word;
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = (r_state == ST_DONE);
    assign err_o         = r_err;

endmodule

// File: tb/tb_poly_compress_pack.sv
// tb/tb_poly_compress_pack.sv - self-checking bench for poly_compress_pack
module tb_poly_compress_pack;
    import athos_pkg::*;

    localparam int N  = 256;
    localparam int QQ = 3329;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [15:0] coeff = 16'd0;
    logic        cvalid = 1'b0;
    logic        cready;
    logic [31:0] word;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        last;
    logic        busy;
    logic        done;
    logic        err;

    poly_compress_pack #(.NCOEFF(N), .Q(QQ)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .mode_i        (mode),
        .coeff_i       (coeff),
        .coeff_valid_i (cvalid),
        .coeff_ready_o (cready),
        .word_o        (word),
        .word_valid_o  (wvalid),
        .word_ready_i  (wready),
        .last_o        (last),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int xs[N];
    logic [31:0] got_w[$];
    bit          got_last[$];
    logic [31:0] exp_w[$];

    typedef struct {
        logic [2:0]   mode;
        logic [127:0] xs;
        logic [31:0]  exp_w0;
        bit           exp_err;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int dof(input logic [2:0] m);
        case (m)
            MODE_D1:  return 1;
            MODE_D4:  return 4;
            MODE_D5:  return 5;
            MODE_D10: return 10;
            MODE_D11: return 11;
            default:  return 1;
        endcase
    endfunction

    function automatic int compress(input int x, input int d);
        int xr;
        xr = x;
        if (xr >= QQ && xr < 2 * QQ) xr = xr - QQ;
        xr = xr % 4096;
        return ((xr * (1 << d) + 1664) / QQ) % (1 << d);
    endfunction

    task automatic build_model(input int d);
        bit stream[$];
        exp_w.delete();
        for (int i = 0; i < N; i++) begin
            int c;
            c = compress(xs[i], d);
            for (int b = 0; b < d; b++) stream.push_back(bit'((c >> b) & 1));
        end
        for (int k = 0; k < stream.size() / 32; k++) begin
            logic [31:0] w;
            w = 32'd0;
            for (int b = 0; b < 32; b++) w[b] = stream[32 * k + b];
            exp_w.push_back(w);
        end
    endtask

    task automatic run_poly(input logic [2:0] m, input int rdy_pct, input int vld_pct,
                            input bit mid_start, input int abort_after);
        int ci = 0;
        int cyc = 0;
        bit held = 0;
        logic [31:0] held_w = 32'd0;
        int last_cyc = -10;
        int done_cyc = -1;
        int last_acc_cyc = -1;
        got_w.delete();
        got_last.delete();
        @(negedge clk);
        mode = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 3'd0;
        #1;
        chk("busy_after_start", busy, 1);
        while (cyc < 5000) begin
            if (abort_after >= 0 && ci >= abort_after) break;
            cvalid = (ci < N) && ($urandom_range(99) < vld_pct);
            coeff  = (ci < N) ? 16'(xs[ci]) : 16'h0;
            wready = ($urandom_range(99) < rdy_pct);
            start  = mid_start && (cyc == 40);
            #1;
            if (held) begin
                chk("stall_valid", wvalid, 1);
                chk("stall_word", word, held_w);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (start) chk("busy_mid_start", busy, 1);
            if (cvalid && cready) begin
                ci++;
                last_acc_cyc = cyc;
            end
            held = 0;
            if (wvalid) begin
                if (wready) begin
                    got_w.push_back(word);
                    got_last.push_back(last);
                    if (last) last_cyc = cyc;
                end else begin
                    held = 1;
                    held_w = word;
                end
            end
            @(negedge clk);
            cyc++;
        end
        cvalid = 1'b0;
        wready = 1'b0;
        start  = 1'b0;
        if (abort_after >= 0) return;
        if (done_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL timeout waiting for done_o words=%0d", got_w.size());
        end else begin
            chk("done_timing", done_cyc, last_cyc + 1);
        end
        if (rdy_pct == 100 && vld_pct == 100) chk("full_rate", last_acc_cyc, N - 1);
        @(negedge clk);
        #1;
        chk("busy_after_done", busy, 0);
        chk("done_pulse_width", done, 0);
    endtask

    task automatic compare_run(input logic [2:0] m, input bit exp_err);
        build_model(dof(m));
        chk("word_count", got_w.size(), exp_w.size());
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            chk($sformatf("word[%0d]", k), got_w[k], exp_w[k]);
            chk($sformatf("last[%0d]", k), got_last[k], (k == exp_w.size() - 1));
        end
        chk("err", err, exp_err);
    endtask

    task automatic check_reset_outputs();
        chk("rst_word", word, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cready", cready, 0);
    endtask

    initial begin
        logic [2:0] modes[5];
        modes = '{MODE_D1, MODE_D4, MODE_D5, MODE_D10, MODE_D11};

        tbl[0] = '{MODE_D1, {16'd0, 16'd0, 16'd0, 16'd0, 16'd3328, 16'd1665, 16'd833, 16'd832}, 32'h00000006, 1'b0};
        tbl[1] = '{MODE_D4, {16'd1665, 16'd1456, 16'd1248, 16'd1040, 16'd832, 16'd624, 16'd416, 16'd208}, 32'h87654321, 1'b0};
        tbl[2] = '{MODE_D4, {16'd1665, 16'd1456, 16'd1248, 16'd1040, 16'd832, 16'd624, 16'd416, 16'd3328}, 32'h87654320, 1'b0};
        tbl[3] = '{MODE_D10, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd2}, 32'h00000401, 1'b0};
        tbl[4] = '{MODE_D11, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd3328, 16'd3328}, 32'h003FFFFF, 1'b0};
        tbl[5] = '{MODE_D5, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1000, 16'd4329}, 32'h0000014A, 1'b0};
        tbl[6] = '{3'd7, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd833, 16'd0, 16'd833}, 32'h00000005, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < N; k++) xs[k] = 0;
            for (int k = 0; k < 8; k++) xs[k] = int'(tbl[i].xs[16 * k +: 16]);
            run_poly(tbl[i].mode, 100, 100, 1'b0, -1);
            chk($sformatf("tbl%0d_word0", i), (got_w.size() > 0) ? got_w[0] : 32'hxxxxxxxx, tbl[i].exp_w0);
            compare_run(tbl[i].mode, tbl[i].exp_err);
        end

        for (int k = 0; k < N; k++) xs[k] = 0;
        run_poly(MODE_D1, 100, 100, 1'b0, -1);
        compare_run(MODE_D1, 1'b0);

        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < N; k++) xs[k] = int'($urandom_range(2 * QQ - 1));
            run_poly(modes[r], 60, 80, 1'b0, -1);
            compare_run(modes[r], 1'b0);
        end

        for (int k = 0; k < N; k++) xs[k] = int'($urandom_range(QQ - 1));
        run_poly(MODE_D11, 50, 100, 1'b1, -1);
        compare_run(MODE_D11, 1'b0);

        for (int k = 0; k < N; k++) xs[k] = int'($urandom_range(2 * QQ - 1));
        run_poly(MODE_D10, 70, 100, 1'b0, 100);
        rst_n  = 1'b0;
        start  = 1'b1;
        cvalid = 1'b1;
        wready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_reset_outputs();
            @(negedge clk);
        end
        start  = 1'b0;
        cvalid = 1'b0;
        wready = 1'b0;
        rst_n  = 1'b1;
        run_poly(MODE_D10, 70, 90, 1'b0, -1);
        compare_run(MODE_D10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
